// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM stage: funct3 encodings, FSM states and lane helpers.
package mem_access_unit_pkg;

    localparam logic [63:0] MEM_BASE_DEFAULT = 64'h8000_0000;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_FULL
    } mau_state_e;

    function automatic int unsigned lane_count(input int unsigned xlen);
        return xlen / 8;
    endfunction

    function automatic int unsigned off_width(input int unsigned xlen);
        return $clog2(xlen / 8);
    endfunction

    // Size alignment check on the byte offset; unsupported store sizes never flag.
    function automatic logic is_misaligned(input logic is_st, input logic [2:0] f3,
                                           input logic [2:0] off);
        logic mis;
        mis = 1'b0;
        if (!(is_st && f3[2]) && f3 != 3'b111) begin
            case (f3[1:0])
                2'b01:   mis = off[0];
                2'b10:   mis = |off[1:0];
                2'b11:   mis = |off;
                default: mis = 1'b0;
            endcase
        end
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_unit_lane.sv
// mem_lane_align: combinational store mask/data lane shifter and load extract/extend.
module mem_lane_align
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned XLEN = 64,
    localparam int unsigned LANES = lane_count(XLEN),
    localparam int unsigned OFFW = off_width(XLEN)
) (
    input  logic [2:0]       funct3_i,
    input  logic [OFFW-1:0]  off_i,
    input  logic [XLEN-1:0]  st_data_i,
    input  logic [XLEN-1:0]  ld_word_i,
    output logic [LANES-1:0] st_mask_o,
    output logic [XLEN-1:0]  st_data_o,
    output logic [XLEN-1:0]  ld_data_o
);

    logic [XLEN-1:0] lane;

    always_comb begin
        st_data_o = st_data_i << {off_i, 3'b000};
        lane      = ld_word_i >> {off_i, 3'b000};
        st_mask_o = '0;
        ld_data_o = '0;

        // Shifted masks are truncated at LANES bits, dropping bytes past the word.
        case (funct3_i)
            F3_B:    st_mask_o = LANES'(4'h1) << off_i;
            F3_H:    st_mask_o = LANES'(4'h3) << off_i;
            F3_W:    st_mask_o = LANES'(4'hF) << off_i;
            F3_D:    st_mask_o = (XLEN == 64) ? '1 : '0;
            default: st_mask_o = '0;
        endcase

        case (funct3_i)
            F3_B:    ld_data_o = XLEN'($signed(lane[7:0]));
            F3_H:    ld_data_o = XLEN'($signed(lane[15:0]));
            F3_W:    ld_data_o = XLEN'($signed(lane[31:0]));
            F3_D:    ld_data_o = (XLEN == 64) ? ld_word_i : '0;
            F3_BU:   ld_data_o = XLEN'(lane[7:0]);
            F3_HU:   ld_data_o = XLEN'(lane[15:0]);
            F3_WU:   ld_data_o = (XLEN == 64) ? XLEN'(lane[31:0]) : '0;
            default: ld_data_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage with request/response memory port and valid/ready output register.
// Define MEM_MISALIGN_TRAP_EN to turn misaligned accesses into flagged no-request results.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned XLEN     = 64,
    parameter logic [63:0] MEM_BASE = MEM_BASE_DEFAULT,
    parameter int unsigned IDX_W    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [31:0]          in_ins,
    input  logic                 in_ld,
    input  logic                 in_st,
    input  logic [2:0]           in_funct3,
    input  logic [XLEN-1:0]      in_addr,
    input  logic [XLEN-1:0]      in_wdata,
    input  logic [4:0]           in_rdest,
    input  logic                 in_reg_w_en,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic                 mem_req_we,
    output logic [IDX_W-1:0]     mem_req_idx,
    output logic [XLEN-1:0]      mem_req_wdata,
    output logic [XLEN/8-1:0]    mem_req_wmask,
    input  logic                 mem_rsp_valid,
    input  logic [XLEN-1:0]      mem_rsp_rdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_pc,
    output logic [31:0]          out_ins,
    output logic                 out_reg_w_en,
    output logic [4:0]           out_rdest,
    output logic [XLEN-1:0]      out_wb_data,
    output logic                 out_misalign,
    output logic                 fwd_reg_w_en,
    output logic [4:0]           fwd_rdest,
    output logic [XLEN-1:0]      fwd_data
);

    localparam int unsigned LANES = lane_count(XLEN);
    localparam int unsigned OFFW  = off_width(XLEN);

    mau_state_e state_q, state_d;

    logic              req_we_q, req_ld_q;
    logic [IDX_W-1:0]  req_idx_q;
    logic [XLEN-1:0]   req_wdata_q;
    logic [2:0]        req_f3_q;
    logic [OFFW-1:0]   req_off_q;
    logic [XLEN-1:0]   pend_pc_q;
    logic [31:0]       pend_ins_q;
    logic [4:0]        pend_rdest_q;
    logic              pend_reg_w_en_q;

    logic [XLEN-1:0]   out_pc_q, out_pc_d;
    logic [31:0]       out_ins_q, out_ins_d;
    logic              out_reg_w_en_q, out_reg_w_en_d;
    logic [4:0]        out_rdest_q, out_rdest_d;
    logic [XLEN-1:0]   out_wb_data_q, out_wb_data_d;
    logic              out_misalign_q, out_misalign_d;

    logic              accept, mem_op, trap, latch_req;
    logic [OFFW-1:0]   in_off;
    logic [XLEN-1:0]   rel_addr;
    logic [LANES-1:0]  al_mask;
    logic [XLEN-1:0]   al_wdata, al_ld_data;

    assign in_ready = (state_q == ST_IDLE) || (state_q == ST_FULL && out_ready);
    assign accept   = in_valid && in_ready;
    assign mem_op   = in_ld || in_st;
    assign in_off   = in_addr[OFFW-1:0];
    assign rel_addr = in_addr - XLEN'(MEM_BASE);

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = mem_op && is_misaligned(in_st, in_funct3, 3'(in_off));
`else
    assign trap = 1'b0;
`endif

    // Aligner runs off the latched request so wdata/wmask stay stable through REQ.
    mem_lane_align #(
        .XLEN(XLEN)
    ) u_align (
        .funct3_i  (req_f3_q),
        .off_i     (req_off_q),
        .st_data_i (req_wdata_q),
        .ld_word_i (mem_rsp_rdata),
        .st_mask_o (al_mask),
        .st_data_o (al_wdata),
        .ld_data_o (al_ld_data)
    );

    always_comb begin
        state_d        = state_q;
        latch_req      = 1'b0;
        out_pc_d       = out_pc_q;
        out_ins_d      = out_ins_q;
        out_reg_w_en_d = out_reg_w_en_q;
        out_rdest_d    = out_rdest_q;
        out_wb_data_d  = out_wb_data_q;
        out_misalign_d = out_misalign_q;

        case (state_q)
            ST_IDLE, ST_FULL: begin
                if (accept) begin
                    if (mem_op && !trap) begin
                        state_d   = ST_REQ;
                        latch_req = 1'b1;
                    end else begin
                        state_d        = ST_FULL;
                        out_pc_d       = in_pc;
                        out_ins_d      = in_ins;
                        out_rdest_d    = in_rdest;
                        out_reg_w_en_d = in_reg_w_en && !trap;
                        out_wb_data_d  = trap ? '0 : in_addr;
                        out_misalign_d = trap;
                    end
                end else if (state_q == ST_FULL && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_rsp_valid) begin
                    state_d        = ST_FULL;
                    out_pc_d       = pend_pc_q;
                    out_ins_d      = pend_ins_q;
                    out_rdest_d    = pend_rdest_q;
                    out_reg_w_en_d = pend_reg_w_en_q;
                    out_wb_data_d  = req_ld_q ? al_ld_data : '0;
                    out_misalign_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            req_we_q        <= 1'b0;
            req_ld_q        <= 1'b0;
            req_idx_q       <= '0;
            req_wdata_q     <= '0;
            req_f3_q        <= '0;
            req_off_q       <= '0;
            pend_pc_q       <= '0;
            pend_ins_q      <= '0;
            pend_rdest_q    <= '0;
            pend_reg_w_en_q <= 1'b0;
            out_pc_q        <= '0;
            out_ins_q       <= '0;
            out_reg_w_en_q  <= 1'b0;
            out_rdest_q     <= '0;
            out_wb_data_q   <= '0;
            out_misalign_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            out_pc_q       <= out_pc_d;
            out_ins_q      <= out_ins_d;
            out_reg_w_en_q <= out_reg_w_en_d;
            out_rdest_q    <= out_rdest_d;
            out_wb_data_q  <= out_wb_data_d;
            out_misalign_q <= out_misalign_d;
            if (latch_req) begin
                req_we_q        <= in_st;
                req_ld_q        <= in_ld;
                req_idx_q       <= IDX_W'(rel_addr >> OFFW);
                req_wdata_q     <= in_wdata;
                req_f3_q        <= in_funct3;
                req_off_q       <= in_off;
                pend_pc_q       <= in_pc;
                pend_ins_q      <= in_ins;
                pend_rdest_q    <= in_rdest;
                pend_reg_w_en_q <= in_reg_w_en;
            end
        end
    end

    assign mem_req_valid = (state_q == ST_REQ);
    assign mem_req_we    = req_we_q;
    assign mem_req_idx   = req_idx_q;
    assign mem_req_wdata = al_wdata;
    assign mem_req_wmask = req_we_q ? al_mask : '0;

    assign out_valid     = (state_q == ST_FULL);
    assign out_pc        = out_pc_q;
    assign out_ins       = out_ins_q;
    assign out_reg_w_en  = out_reg_w_en_q;
    assign out_rdest     = out_rdest_q;
    assign out_wb_data   = out_wb_data_q;
    assign out_misalign  = out_misalign_q;

    assign fwd_reg_w_en  = in_reg_w_en && in_valid;
    assign fwd_rdest     = in_rdest;
    assign fwd_data      = in_ld ? '0 : in_addr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (XLEN=64).
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ld, in_st, in_reg_w_en;
    logic        in_ready;
    logic [63:0] in_pc, in_addr, in_wdata;
    logic [31:0] in_ins;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rdest;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0] mem_req_idx;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_rdata;
    logic        out_valid, out_ready, out_reg_w_en, out_misalign;
    logic [63:0] out_pc, out_wb_data;
    logic [31:0] out_ins;
    logic [4:0]  out_rdest;
    logic        fwd_reg_w_en;
    logic [4:0]  fwd_rdest;
    logic [63:0] fwd_data;

    int n_cmp = 0;
    int n_err = 0;

    logic        cap_we, cap_rwe, cap_ov, got_req;
    logic [31:0] cap_idx;
    logic [7:0]  cap_mask;
    logic [63:0] cap_wdata, cap_wb;

    mem_access_unit #(
        .XLEN(64),
        .MEM_BASE(64'h8000_0000),
        .IDX_W(32)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_ins(in_ins),
        .in_ld(in_ld), .in_st(in_st), .in_funct3(in_funct3), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_rdest(in_rdest), .in_reg_w_en(in_reg_w_en),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_idx(mem_req_idx),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_ins(out_ins),
        .out_reg_w_en(out_reg_w_en), .out_rdest(out_rdest), .out_wb_data(out_wb_data),
        .out_misalign(out_misalign),
        .fwd_reg_w_en(fwd_reg_w_en), .fwd_rdest(fwd_rdest), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full memory transaction with immediate request accept and response.
    task automatic mem_txn(input string tag, input logic ld, input logic st,
                           input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] wd, input logic [63:0] rd);
        in_valid = 1'b1; in_ld = ld; in_st = st; in_funct3 = f3;
        in_addr = addr; in_wdata = wd; in_rdest = 5'd9; in_reg_w_en = ld;
        #1;
        if (ld) check_eq({tag, "_fwd"}, fwd_data, 64'h0);
        tick();
        in_valid = 1'b0; in_ld = 1'b0; in_st = 1'b0;
        got_req = 1'b0;
        for (int i = 0; i < 10 && !got_req; i++) begin
            if (mem_req_valid) got_req = 1'b1;
            else tick();
        end
        check_eq({tag, "_req"}, 64'(got_req), 64'h1);
        if (!got_req) return;
        cap_we = mem_req_we; cap_idx = mem_req_idx;
        cap_mask = mem_req_wmask; cap_wdata = mem_req_wdata;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_rdata = rd;
        tick();
        mem_rsp_valid = 1'b0;
        cap_ov = out_valid; cap_wb = out_wb_data; cap_rwe = out_reg_w_en;
        check_eq({tag, "_ov"}, 64'(cap_ov), 64'h1);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 0; in_ld = 0; in_st = 0; in_reg_w_en = 0; in_funct3 = 0;
        in_pc = 64'h200; in_ins = 32'h13; in_addr = 0; in_wdata = 0; in_rdest = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = 0; out_ready = 1;
        #2 reset = 1'b0;
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'h0);
        check_eq("rst_req_valid", 64'(mem_req_valid), 64'h0);
        check_eq("rst_in_ready", 64'(in_ready), 64'h1);
        check_eq("rst_wb", out_wb_data, 64'h0);
        check_eq("rst_pc", out_pc, 64'h0);
        check_eq("rst_mis", 64'(out_misalign), 64'h0);
        tick(); tick();
        reset = 1'b1;

        // ALU results, back-to-back
        in_valid = 1; in_addr = 64'h1234; in_rdest = 5'd5; in_reg_w_en = 1; in_pc = 64'h100;
        #1;
        check_eq("alu_fwd_data", fwd_data, 64'h1234);
        check_eq("alu_fwd_wen", 64'(fwd_reg_w_en), 64'h1);
        tick();
        check_eq("alu_ov", 64'(out_valid), 64'h1);
        check_eq("alu_wb", out_wb_data, 64'h1234);
        check_eq("alu_rd", 64'(out_rdest), 64'h5);
        check_eq("alu_pc", out_pc, 64'h100);
        check_eq("alu_in_ready", 64'(in_ready), 64'h1);
        in_addr = 64'h5678; in_rdest = 5'd6;
        tick();
        check_eq("alu2_ov", 64'(out_valid), 64'h1);
        check_eq("alu2_wb", out_wb_data, 64'h5678);
        in_valid = 0;
        tick();
        check_eq("alu_drain_ov", 64'(out_valid), 64'h0);

        // Loads
        mem_txn("lb", 1, 0, 3'b000, 64'h8000_0013, 0, 64'h0000_0000_80FF_0000);
        check_eq("lb_idx", 64'(cap_idx), 64'h2);
        check_eq("lb_we", 64'(cap_we), 64'h0);
        check_eq("lb_wb", cap_wb, 64'hFFFF_FFFF_FFFF_FF80);
        check_eq("lb_rwe", 64'(cap_rwe), 64'h1);
        mem_txn("lbu", 1, 0, 3'b100, 64'h8000_0013, 0, 64'h0000_0000_80FF_0000);
        check_eq("lbu_wb", cap_wb, 64'h80);
        mem_txn("lh", 1, 0, 3'b001, 64'h8000_0012, 0, 64'h0000_0000_80FF_0000);
        check_eq("lh_wb", cap_wb, 64'hFFFF_FFFF_FFFF_80FF);
        mem_txn("lw", 1, 0, 3'b010, 64'h8000_0004, 0, 64'h8765_4321_0000_0000);
        check_eq("lw_wb", cap_wb, 64'hFFFF_FFFF_8765_4321);
        mem_txn("lwu", 1, 0, 3'b110, 64'h8000_0004, 0, 64'h8765_4321_0000_0000);
        check_eq("lwu_wb", cap_wb, 64'h0000_0000_8765_4321);
        mem_txn("ld", 1, 0, 3'b011, 64'h8000_0008, 0, 64'h0123_4567_89AB_CDEF);
        check_eq("ld_idx", 64'(cap_idx), 64'h1);
        check_eq("ld_wb", cap_wb, 64'h0123_4567_89AB_CDEF);
        mem_txn("lbad", 1, 0, 3'b111, 64'h8000_0000, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("lbad_wb", cap_wb, 64'h0);

        // Stores
        mem_txn("sh", 0, 1, 3'b001, 64'h8000_0006, 64'hABCD, 0);
        check_eq("sh_idx", 64'(cap_idx), 64'h0);
        check_eq("sh_mask", 64'(cap_mask), 64'hC0);
        check_eq("sh_wdata", cap_wdata, 64'hABCD_0000_0000_0000);
        check_eq("sh_we", 64'(cap_we), 64'h1);
        check_eq("sh_wb", cap_wb, 64'h0);
        mem_txn("sb", 0, 1, 3'b000, 64'h8000_0025, 64'h115A, 0);
        check_eq("sb_idx", 64'(cap_idx), 64'h4);
        check_eq("sb_mask", 64'(cap_mask), 64'h20);
        check_eq("sb_wdata", cap_wdata, 64'h0011_5A00_0000_0000);
        mem_txn("sd", 0, 1, 3'b011, 64'h8000_0018, 64'hDEAD_BEEF_0BAD_F00D, 0);
        check_eq("sd_idx", 64'(cap_idx), 64'h3);
        check_eq("sd_mask", 64'(cap_mask), 64'hFF);
        check_eq("sd_wdata", cap_wdata, 64'hDEAD_BEEF_0BAD_F00D);
        mem_txn("sbad", 0, 1, 3'b100, 64'h8000_0000, 64'h1, 0);
        check_eq("sbad_mask", 64'(cap_mask), 64'h0);

        // Stalled request then delayed response; stray response during REQ is ignored
        in_valid = 1; in_ld = 1; in_funct3 = 3'b010; in_addr = 64'h8000_0010; in_reg_w_en = 1;
        tick();
        in_valid = 0; in_ld = 0;
        mem_rsp_rdata = 64'h0000_0001_FFFF_FFFE;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            mem_req_ready = (cyc == 4);
            mem_rsp_valid = (cyc == 2) || (cyc == 6);
            #1;
            check_eq($sformatf("lat_in_ready_%0d", cyc), 64'(in_ready), 64'h0);
            check_eq($sformatf("lat_req_valid_%0d", cyc), 64'(mem_req_valid), 64'(cyc <= 4));
            if (cyc <= 4) check_eq($sformatf("lat_idx_%0d", cyc), 64'(mem_req_idx), 64'h2);
            tick();
            check_eq($sformatf("lat_ov_%0d", cyc), 64'(out_valid), 64'(cyc == 6));
        end
        mem_req_ready = 0; mem_rsp_valid = 0;
        check_eq("lat_wb", out_wb_data, 64'hFFFF_FFFF_FFFF_FFFE);

        // Output back-pressure
        out_ready = 0;
        in_valid = 1; in_addr = 64'h77;
        #1;
        check_eq("bp_in_ready", 64'(in_ready), 64'h0);
        tick(); tick();
        check_eq("bp_ov", 64'(out_valid), 64'h1);
        check_eq("bp_wb", out_wb_data, 64'hFFFF_FFFF_FFFF_FFFE);
        in_valid = 0; out_ready = 1;
        #1;
        check_eq("bp_rel_in_ready", 64'(in_ready), 64'h1);
        tick();
        check_eq("bp_drain_ov", 64'(out_valid), 64'h0);

        // Reset in WAIT, then a late response
        in_valid = 1; in_ld = 1; in_funct3 = 3'b000; in_addr = 64'h8000_0000;
        tick();
        in_valid = 0; in_ld = 0; mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        check_eq("wait_in_ready", 64'(in_ready), 64'h0);
        #2 reset = 1'b0;
        #1;
        check_eq("mid_rst_req", 64'(mem_req_valid), 64'h0);
        check_eq("mid_rst_ov", 64'(out_valid), 64'h0);
        check_eq("mid_rst_wb", out_wb_data, 64'h0);
        check_eq("mid_rst_in_ready", 64'(in_ready), 64'h1);
        reset = 1'b1;
        mem_rsp_valid = 1; mem_rsp_rdata = 64'h55;
        tick();
        mem_rsp_valid = 0;
        check_eq("late_rsp_ov", 64'(out_valid), 64'h0);
        check_eq("late_rsp_in_ready", 64'(in_ready), 64'h1);
        check_eq("late_rsp_req", 64'(mem_req_valid), 64'h0);

`ifdef MEM_MISALIGN_TRAP_EN
        in_valid = 1; in_ld = 1; in_funct3 = 3'b010; in_addr = 64'h8000_0002; in_reg_w_en = 1;
        tick();
        in_valid = 0; in_ld = 0;
        check_eq("trap_ov", 64'(out_valid), 64'h1);
        check_eq("trap_req", 64'(mem_req_valid), 64'h0);
        check_eq("trap_mis", 64'(out_misalign), 64'h1);
        check_eq("trap_rwe", 64'(out_reg_w_en), 64'h0);
        check_eq("trap_wb", out_wb_data, 64'h0);
        tick();
`else
        mem_txn("sw_mis", 0, 1, 3'b010, 64'h8000_0006, 64'h1122_3344, 0);
        check_eq("sw_mis_mask", 64'(cap_mask), 64'hC0);
        check_eq("sw_mis_wdata", cap_wdata, 64'h3344_0000_0000_0000);
        check_eq("sw_mis_flag", 64'(out_misalign), 64'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
